// File: rtl/vec_wb_arbiter.sv
// Vector writeback: ALU result FIFO, round-robin VRF arbitration against load returns, scalar results to SRF.
// ALU result reaches the RF 2 cycles after alu_valid, loads 1 cycle after grant; the ALU is throttled only via alu_ready.
module vec_wb_arbiter #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic [4:0]        alu_rd,
  input  logic              alu_is_scalar,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              alu_err_overflow,
  input  logic              alu_err_invalid,
  output logic              alu_ready,
  input  logic              ld_valid,
  input  logic [4:0]        ld_rd,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              vrf_we,
  output logic [4:0]        vrf_waddr,
  output logic [DATA_W-1:0] vrf_wdata,
  output logic              srf_we,
  output logic [4:0]        srf_waddr,
  output logic [31:0]       srf_wdata,
  input  logic              err_clr,
  output logic              err_overflow,
  output logic              err_invalid,
  output logic              fifo_drop,
  output logic              busy
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] L_FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0] L_RDY_MAX = (AW+1)'(DEPTH - 2);

  typedef enum logic {GNT_ALU = 1'b0, GNT_LOAD = 1'b1} gnt_e;

  logic [4:0]        r_rd_q  [DEPTH];
  logic              r_sc_q  [DEPTH];
  logic [DATA_W-1:0] r_dat_q [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [AW:0]       r_count;
  gnt_e              r_last;
  gnt_e              w_last_nxt;

  logic              r_vrf_we;
  logic [4:0]        r_vrf_waddr;
  logic [DATA_W-1:0] r_vrf_wdata;
  logic              r_srf_we;
  logic [4:0]        r_srf_waddr;
  logic [31:0]       r_srf_wdata;
  logic              r_drop;
  logic              r_err_ovf;
  logic              r_err_inv;

  logic              w_empty;
  logic              w_full;
  logic [4:0]        w_head_rd;
  logic              w_head_sc;
  logic [DATA_W-1:0] w_head_dat;
  logic              w_vec_head;
  logic              w_sc_head;
  logic              w_ld_ready;
  logic              w_ld_go;
  logic              w_alu_gnt;
  logic              w_pop;
  logic              w_push;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == L_FULL);
  assign w_head_rd  = r_rd_q[r_rptr];
  assign w_head_sc  = r_sc_q[r_rptr];
  assign w_head_dat = r_dat_q[r_rptr];
  assign w_vec_head = !w_empty && !w_head_sc;
  assign w_sc_head  = !w_empty && w_head_sc;

  // A full FIFO always wins the VRF port, so a full FIFO always pops.
  always_comb begin
    w_last_nxt = r_last;
    w_ld_ready = !(w_vec_head && (r_last == GNT_LOAD || w_full));
    w_ld_go    = ld_valid && w_ld_ready;
    w_alu_gnt  = w_vec_head && !w_ld_go;
    w_pop      = w_sc_head || w_alu_gnt;
    w_push     = alu_valid && (!w_full || w_pop);
    if (w_alu_gnt) begin
      w_last_nxt = GNT_ALU;
    end else if (w_ld_go) begin
      w_last_nxt = GNT_LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd_q[r_wptr]  <= alu_rd;
      r_sc_q[r_wptr]  <= alu_is_scalar;
      r_dat_q[r_wptr] <= alu_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_last  <= GNT_ALU;
    end else begin
      r_last  <= w_last_nxt;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vrf_we    <= 1'b0;
      r_vrf_waddr <= '0;
      r_vrf_wdata <= '0;
      r_srf_we    <= 1'b0;
      r_srf_waddr <= '0;
      r_srf_wdata <= '0;
      r_drop      <= 1'b0;
      r_err_ovf   <= 1'b0;
      r_err_inv   <= 1'b0;
    end else begin
      r_vrf_we <= w_alu_gnt || w_ld_go;
      if (w_alu_gnt) begin
        r_vrf_waddr <= w_head_rd;
        r_vrf_wdata <= w_head_dat;
      end else if (w_ld_go) begin
        r_vrf_waddr <= ld_rd;
        r_vrf_wdata <= ld_data;
      end
      // Scalar x0 is hardwired zero: the entry drains without a write.
      r_srf_we <= w_sc_head && (w_head_rd != 5'd0);
      if (w_sc_head) begin
        r_srf_waddr <= w_head_rd;
        r_srf_wdata <= w_head_dat[31:0];
      end
      r_drop    <= alu_valid && !w_push;
      r_err_ovf <= (r_err_ovf && !err_clr) || (alu_valid && alu_err_overflow);
      r_err_inv <= (r_err_inv && !err_clr) || (alu_valid && alu_err_invalid);
    end
  end

  assign alu_ready    = (r_count <= L_RDY_MAX);
  assign ld_ready     = w_ld_ready;
  assign vrf_we       = r_vrf_we;
  assign vrf_waddr    = r_vrf_waddr;
  assign vrf_wdata    = r_vrf_wdata;
  assign srf_we       = r_srf_we;
  assign srf_waddr    = r_srf_waddr;
  assign srf_wdata    = r_srf_wdata;
  assign err_overflow = r_err_ovf;
  assign err_invalid  = r_err_inv;
  assign fifo_drop    = r_drop;
  assign busy         = !w_empty || r_vrf_we || r_srf_we;
endmodule

// File: tb/tb_vec_wb_arbiter.sv
// Directed bench for vec_wb_arbiter: hand-computed write order, ready and sticky-flag expectations.
module tb_vec_wb_arbiter;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         alu_valid;
  logic [4:0]   alu_rd;
  logic         alu_is_scalar;
  logic [127:0] alu_data;
  logic         alu_err_overflow;
  logic         alu_err_invalid;
  logic         alu_ready;
  logic         ld_valid;
  logic [4:0]   ld_rd;
  logic [127:0] ld_data;
  logic         ld_ready;
  logic         vrf_we;
  logic [4:0]   vrf_waddr;
  logic [127:0] vrf_wdata;
  logic         srf_we;
  logic [4:0]   srf_waddr;
  logic [31:0]  srf_wdata;
  logic         err_clr;
  logic         err_overflow;
  logic         err_invalid;
  logic         fifo_drop;
  logic         busy;

  int n_chk  = 0;
  int n_fail = 0;
  logic [127:0] vq[$];

  vec_wb_arbiter #(.DATA_W(128), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_is_scalar(alu_is_scalar), .alu_data(alu_data),
    .alu_err_overflow(alu_err_overflow), .alu_err_invalid(alu_err_invalid), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
    .vrf_we(vrf_we), .vrf_waddr(vrf_waddr), .vrf_wdata(vrf_wdata),
    .srf_we(srf_we), .srf_waddr(srf_waddr), .srf_wdata(srf_wdata),
    .err_clr(err_clr), .err_overflow(err_overflow), .err_invalid(err_invalid),
    .fifo_drop(fifo_drop), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && vrf_we) vq.push_back(vrf_wdata);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_chk, n_fail);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0; alu_rd = '0; alu_is_scalar = 1'b0; alu_data = '0;
    alu_err_overflow = 1'b0; alu_err_invalid = 1'b0;
    ld_valid = 1'b0; ld_rd = '0; ld_data = '0; err_clr = 1'b0;
  endtask

  task automatic rst_checks(input string p);
    chk({p, "_vrf_we"}, vrf_we, 0);
    chk({p, "_vrf_waddr"}, vrf_waddr, 0);
    chk({p, "_vrf_wdata"}, vrf_wdata, 0);
    chk({p, "_srf_we"}, srf_we, 0);
    chk({p, "_srf_waddr"}, srf_waddr, 0);
    chk({p, "_srf_wdata"}, srf_wdata, 0);
    chk({p, "_err_ovf"}, err_overflow, 0);
    chk({p, "_err_inv"}, err_invalid, 0);
    chk({p, "_drop"}, fifo_drop, 0);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_alu_ready"}, alu_ready, 1);
    chk({p, "_ld_ready"}, ld_ready, 1);
  endtask

  initial begin
    int li;
    int n0;
    logic [127:0] v;
    logic [127:0] e;
    logic [8:0] exp_ardy;
    logic [8:0] exp_lrdy;

    rst_n = 1'b1;
    idle();
    #1 rst_n = 1'b0;
    #1 rst_checks("rst");
    #10 rst_n = 1'b1;
    step();

    // Single vector result through an empty pipe
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 128'h1;
    step();
    idle();
    chk("single_c1_vrf_we", vrf_we, 0);
    chk("single_c1_busy", busy, 1);
    step();
    chk("single_c2_vrf_we", vrf_we, 1);
    chk("single_c2_waddr", vrf_waddr, 5);
    chk("single_c2_wdata", vrf_wdata, 128'h1);
    step();
    chk("single_c3_busy", busy, 0);
    chk("single_c3_vrf_we", vrf_we, 0);
    step();

    // Continuous contention: 4 ALU results vs 4 loads
    vq.delete();
    li = 0;
    for (int c = 0; c < 12; c++) begin
      alu_valid = (c < 4);
      alu_rd    = 5'(c);
      alu_data  = 128'hA0 + 128'(c);
      ld_valid  = (c >= 1) && (li < 4);
      ld_rd     = 5'(li + 8);
      ld_data   = 128'hB0 + 128'(li);
      if (ld_valid && ld_ready) li++;
      step();
    end
    idle();
    step();
    chk("cont_count", vq.size(), 8);
    for (int k = 0; k < 8; k++) begin
      v = (k < vq.size()) ? vq[k] : '1;
      e = (k % 2 == 0) ? (128'hB0 + 128'(k / 2)) : (128'hA0 + 128'(k / 2));
      chk($sformatf("cont_w%0d", k), v, e);
    end

    // Fill towards full with loads held; full FIFO must beat the load
    vq.delete();
    li = 0;
    exp_ardy = 9'b000011111;
    exp_lrdy = 9'b001010101;
    for (int c = 0; c < 9; c++) begin
      alu_valid = (c < 8);
      alu_rd    = 5'(c + 16);
      alu_data  = 128'hD0 + 128'(c);
      ld_valid  = 1'b1;
      ld_rd     = 5'(li);
      ld_data   = 128'hC0 + 128'(li);
      chk($sformatf("fill_alu_ready_c%0d", c), alu_ready, exp_ardy[c]);
      chk($sformatf("fill_ld_ready_c%0d", c), ld_ready, exp_lrdy[c]);
      if (c == 8) chk("fill_no_drop_on_full_pop", fifo_drop, 0);
      if (ld_ready) li++;
      step();
    end
    idle();
    for (int c = 0; c < 6; c++) step();
    chk("fill_count", vq.size(), 12);
    for (int k = 0; k < 12; k++) begin
      v = (k < vq.size()) ? vq[k] : '1;
      if (k < 8) e = (k % 2 == 0) ? (128'hC0 + 128'(k / 2)) : (128'hD0 + 128'(k / 2));
      else       e = 128'hD0 + 128'(k - 4);
      chk($sformatf("fill_w%0d", k), v, e);
    end

    // Scalar head coinciding with a load
    alu_valid = 1'b1; alu_is_scalar = 1'b1; alu_rd = 5'd3;
    alu_data = {96'h1234, 32'h0000000F};
    step();
    idle();
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 128'h77;
    chk("sc_ld_ready", ld_ready, 1);
    step();
    idle();
    chk("sc_srf_we", srf_we, 1);
    chk("sc_srf_waddr", srf_waddr, 3);
    chk("sc_srf_wdata", srf_wdata, 32'hF);
    chk("sc_vrf_we", vrf_we, 1);
    chk("sc_vrf_waddr", vrf_waddr, 7);
    chk("sc_vrf_wdata", vrf_wdata, 128'h77);
    step();

    // Sticky errors, using scalar rd=0 pushes
    alu_valid = 1'b1; alu_is_scalar = 1'b1; alu_rd = 5'd0; alu_err_overflow = 1'b1;
    step();
    idle();
    chk("err_ovf_set", err_overflow, 1);
    chk("err_inv_clear", err_invalid, 0);
    err_clr = 1'b1;
    step();
    chk("sc_rd0_no_write", srf_we, 0);
    chk("err_ovf_cleared", err_overflow, 0);
    err_clr = 1'b1; alu_valid = 1'b1; alu_is_scalar = 1'b1; alu_rd = 5'd0; alu_err_invalid = 1'b1;
    step();
    idle();
    chk("err_inv_set_wins", err_invalid, 1);
    chk("err_ovf_stays_clear", err_overflow, 0);
    step();
    chk("sc_rd0_no_write2", srf_we, 0);
    chk("sc_rd0_busy", busy, 0);

    // Reset with 3 entries queued
    for (int c = 0; c < 5; c++) begin
      alu_valid = 1'b1; alu_is_scalar = 1'b0; alu_rd = 5'(c);
      alu_data = 128'hE0 + 128'(c);
      ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 128'hF0;
      step();
    end
    idle();
    chk("midrst_alu_ready_pre", alu_ready, 0);
    #2 rst_n = 1'b0;
    #1 rst_checks("midrst");
    #2 rst_n = 1'b1;
    n0 = vq.size();
    for (int c = 0; c < 6; c++) step();
    chk("midrst_no_stale_writes", vq.size(), n0);
    chk("midrst_alu_ready_post", alu_ready, 1);
    chk("midrst_busy_post", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
